sc_lane_accumulator: RTL and testbench
======================================

# sc_lane_accumulator

Parallel-lane stochastic-to-binary converter sitting directly downstream of the deterministic stochastic multipliers. Each cycle it consumes a vector of LANES product bitstream bits, popcounts it, and accumulates the count over one multiply run delimited by `start` and `last`. It then presents the binary result on a valid/ready handshake to the next stage. It replaces free-running lane accumulators that have no run framing or backpressure.

## Interface
- `LANES`, default 4: number of bitstream lanes; power of 2, 2..32.
- `WIDTH`, default 10: result and accumulator width in bits.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a new run; clears the accumulator and `overflow`.
- `lane_in` in LANES: product bitstream bits for one cycle.
- `lane_vld` in 1: `lane_in` is a valid beat this cycle.
- `last` in 1: qualifies the final beat of the run; driven from the multiplier `done`; meaningful only with `lane_vld`.
- `countval` out WIDTH: accumulated result; stable while `res_vld` is high.
- `res_vld` out 1: result available.
- `res_rdy` in 1: downstream accepts the result.
- `overflow` out 1: sticky flag; the accumulation exceeded 2^WIDTH-1 during the run.
- `busy` out 1: high in ACC, DRAIN and HOLD; upstream must not start a new multiply while high, except on the handshake cycle.

## Operation
- **States:** IDLE, ACC, DRAIN, HOLD.
- **IDLE:**
  - `start` → ACC; the accumulator clears to 0 and `overflow` clears.
  - `lane_vld` without `start` is ignored.
- **ACC:**
  - Each `lane_vld` beat: popcount of `lane_in` (width $clog2(LANES)+1) is registered in stage 1, then added to the accumulator in stage 2.
  - A beat with `lane_vld & last` → DRAIN.
- **DRAIN:** one cycle; the pipeline empties → HOLD.
- **HOLD:**
  - `res_vld`=1.
  - `res_vld & res_rdy` → IDLE. If `start` is high in the same cycle → ACC directly, with a fresh clear.
  - `lane_vld` is ignored.
  - `start` without `res_rdy` is ignored.
- **start while in ACC or DRAIN:** restart. Clear the accumulator and `overflow`, flush the stage-1 register, stay in or return to ACC. A `lane_vld` beat in the same cycle as `start` counts as the first beat of the new run.
- **start together with a last beat:** the beat is the only beat of the new run → DRAIN.
- **Arithmetic:** zero-extend the popcount to WIDTH+1, add it, and carry-out sets `overflow`. Saturation behaviour is given under Configuration.

## Timing
- **Reset:** state=IDLE; `countval`=0, `res_vld`=0, `overflow`=0, `busy`=0; pipeline registers 0. Reset asserted mid-run aborts the run with no result emitted.
- **First beat:** `start` sampled at edge E0 → `busy`=1 after E0. A beat may accompany `start` at E0.
- **Result latency:** last beat sampled at edge Ek → `res_vld`=1 after edge Ek+2, with `countval` final.
- **Back-to-back beats:** every cycle, no bubbles; throughput is 1 beat per clock.
- **Handshake:**
  - `res_vld` falls after the edge where `res_vld & res_rdy`.
  - `countval` holds its value until the next `start` clears it.
  - `res_rdy` outside HOLD has no effect.

## Configuration
- `SC_ACC_SAT_EN` defined: on overflow the accumulator saturates at 2^WIDTH-1 and stays there for the rest of the run; `overflow`=1.
- `SC_ACC_SAT_EN` undefined: the accumulator wraps modulo 2^WIDTH; `overflow` is still set sticky on the first carry-out.

## Structure
- **Package `sc_acc_pkg`:** state enum typedef (IDLE/ACC/DRAIN/HOLD) and a popcount-width constant function.
- **Sub-module `sc_popcount_tree`:** combinational adder-tree popcount, parameterized by LANES; its output is registered in the parent as stage 1.
- **Parent:** FSM, stage-1 register, accumulator, result register.

## Test plan
- **Basic run:** LANES=4, WIDTH=10. `start`; beats 4'b1111, 4'b1111, 4'b1111, 4'b0101 (`last` on the 4th); `res_rdy`=1 → `countval`=14 and `res_vld` 2 cycles after the last beat, `overflow`=0.
- **Saturation/wrap:** WIDTH=4. Five beats of 4'b1111 → with `SC_ACC_SAT_EN`, `countval`=15; without it, `countval`=4. `overflow`=1 in both builds.
- **Backpressure:** hold `res_rdy`=0 for 5 cycles in HOLD while driving `lane_vld`=1 with 4'b1111 → `res_vld`=1 and `countval` unchanged throughout. Then `res_rdy`=1 → IDLE next cycle.
- **Restart:** `start`, two beats of 4'b0011, then `start` with beat 4'b0001 marked `last` → `countval`=1.
- **Handshake plus start:** `start` asserted with `res_rdy` in HOLD → `busy` stays 1, state ACC, `countval` cleared to 0.
- **Reset mid-run:** assert `rst` one cycle after 3 beats → all outputs 0 and IDLE. A following `last` beat without `start` is ignored, and `res_vld` stays 0.

Source files
------------

// File: rtl/sc_acc_pkg.sv
// rtl/sc_acc_pkg.sv - shared types and helpers for the stochastic lane accumulator
package sc_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Bits needed to hold a popcount of 0..lanes
    function automatic int pc_width(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/sc_popcount_tree.sv
// rtl/sc_popcount_tree.sv - combinational adder-tree popcount over LANES bits
module sc_popcount_tree
    import sc_acc_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]             lane_in,
    output logic [pc_width(LANES)-1:0]   count
);

    localparam int PW = pc_width(LANES);

    // Heap-ordered tree: leaves at LANES..2*LANES-1, node j sums children 2j and 2j+1
    logic [PW-1:0] node [1:2*LANES-1];

    for (genvar i = 0; i < LANES; i++) begin : g_leaf
        assign node[LANES+i] = PW'(lane_in[i]);
    end

    for (genvar j = 1; j < LANES; j++) begin : g_sum
        assign node[j] = node[2*j] + node[2*j+1];
    end

    assign count = node[1];

endmodule

// File: rtl/sc_lane_accumulator.sv
// rtl/sc_lane_accumulator.sv - run-framed lane popcount accumulator with result handshake; SC_ACC_SAT_EN selects saturation
module sc_lane_accumulator
    import sc_acc_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LANES-1:0] lane_in,
    input  logic             lane_vld,
    input  logic             last,
    output logic [WIDTH-1:0] countval,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic             overflow,
    output logic             busy
);

    localparam int PW = pc_width(LANES);

    state_t          state;
    logic [PW-1:0]   pc_now;
    logic [PW-1:0]   s1_cnt;
    logic            s1_vld;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]  sum;
    logic            restart;

    sc_popcount_tree #(.LANES(LANES)) u_popcount (
        .lane_in (lane_in),
        .count   (pc_now)
    );

    // Stage-2 adder: zero-extended popcount plus one carry bit to detect overflow
    assign sum = {1'b0, acc} + (WIDTH+1)'(s1_cnt);

    // start is honoured everywhere except HOLD, where it needs the result handshake too
    assign restart = start & ((state != ST_HOLD) | (res_vld & res_rdy));

    // FSM, stage-1 register, accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            s1_cnt   <= '0;
            s1_vld   <= 1'b0;
            acc      <= '0;
            countval <= '0;
            res_vld  <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else if (restart) begin
            // Fresh run: anything in stage 1 is discarded, an accompanying beat is beat one
            acc      <= '0;
            overflow <= 1'b0;
            countval <= '0;
            res_vld  <= 1'b0;
            busy     <= 1'b1;
            s1_vld   <= lane_vld;
            s1_cnt   <= lane_vld ? pc_now : '0;
            state    <= (lane_vld & last) ? ST_DRAIN : ST_ACC;
        end else begin
            s1_vld <= 1'b0;
            if ((state == ST_ACC || state == ST_DRAIN) && s1_vld) begin
                if (sum[WIDTH]) begin
                    overflow <= 1'b1;
`ifdef SC_ACC_SAT_EN
                    acc <= '1;
`else
                    acc <= sum[WIDTH-1:0];
`endif
                end else begin
                    acc <= sum[WIDTH-1:0];
                end
            end
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                ST_ACC: begin
                    s1_vld <= lane_vld;
                    if (lane_vld) begin
                        s1_cnt <= pc_now;
                    end
                    if (lane_vld & last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // First HOLD cycle latches the settled accumulator into the result register
                    if (!res_vld) begin
                        countval <= acc;
                        res_vld  <= 1'b1;
                    end else if (res_rdy) begin
                        res_vld <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_lane_accumulator.sv
// tb/tb_sc_lane_accumulator.sv - table-driven scoreboard bench for sc_lane_accumulator
module tb_sc_lane_accumulator;

    localparam int LANES = 4;
    localparam int WIDTH = 4;

`ifdef SC_ACC_SAT_EN
    localparam logic [3:0] EXP_SUM20 = 4'd15;
    localparam logic [3:0] EXP_SUM17 = 4'd15;
`else
    localparam logic [3:0] EXP_SUM20 = 4'd4;
    localparam logic [3:0] EXP_SUM17 = 4'd1;
`endif

    typedef struct {
        string       name;
        logic [23:0] beats;
        int          n;
        logic [3:0]  cnt;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [3:0] cnt;
        logic       ov;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LANES-1:0] lane_in;
    logic             lane_vld;
    logic             last;
    logic [WIDTH-1:0] countval;
    logic             res_vld;
    logic             res_rdy;
    logic             overflow;
    logic             busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[7];

    sc_lane_accumulator #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .lane_in  (lane_in),
        .lane_vld (lane_vld),
        .last     (last),
        .countval (countval),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [23:0] beats, input int n,
                                input logic [3:0] cnt, input logic ov);
        vec_t v;
        v.name = name; v.beats = beats; v.n = n; v.cnt = cnt; v.ov = ov;
        return v;
    endfunction

    // Drive a run with start on the first beat; push the expectation with the last beat
    task automatic drive_run(input logic [23:0] beats, input int n, input logic [3:0] cnt, input logic ov);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            start    = (b == 0);
            lane_vld = 1'b1;
            lane_in  = beats[b*4 +: 4];
            last     = (b == n - 1);
        end
        e.cnt = cnt; e.ov = ov;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; lane_vld = 1'b0; last = 1'b0; lane_in = '0;
    endtask

    // Wait (bounded) for res_vld, counting cycles after the last-beat edge
    task automatic wait_res(input string name, output int lat);
        lat = 0;
        while (!res_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!res_vld) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_countval"}, countval, e.cnt);
            chk({name, "_overflow"}, overflow, e.ov);
        end
    endtask

    initial begin
        int lat;

        vecs[0] = mk("basic",   {8'h00, 4'b0101, 4'b1111, 4'b1111, 4'b1111}, 4, 4'd14, 1'b0);
        vecs[1] = mk("five_ff", {4'h0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111}, 5, EXP_SUM20, 1'b1);
        vecs[2] = mk("zero",    {20'h0, 4'b0000}, 1, 4'd0, 1'b0);
        vecs[3] = mk("single",  {20'h0, 4'b1010}, 1, 4'd2, 1'b0);
        vecs[4] = mk("walk",    {4'h0, 4'b1110, 4'b0001, 4'b0010, 4'b0100, 4'b1000}, 5, 4'd7, 1'b0);
        vecs[5] = mk("max",     {8'h00, 4'b0111, 4'b1111, 4'b1111, 4'b1111}, 4, 4'd15, 1'b0);
        vecs[6] = mk("over17",  {4'h0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0001}, 5, EXP_SUM17, 1'b1);

        rst = 1'b1; start = 1'b0; lane_in = '0; lane_vld = 1'b0; last = 1'b0; res_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_countval", countval, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);

        // Table runs: latency, result, overflow, handshake release
        for (int i = 0; i < 7; i++) begin
            drive_run(vecs[i].beats, vecs[i].n, vecs[i].cnt, vecs[i].ov);
            wait_res(vecs[i].name, lat);
            chk({vecs[i].name, "_latency"}, lat, 2);
            chk({vecs[i].name, "_busy_hold"}, busy, 1);
            pop_cmp(vecs[i].name);
            res_rdy = 1'b1;
            @(negedge clk);
            res_rdy = 1'b0;
            chk({vecs[i].name, "_res_vld_drop"}, res_vld, 0);
            chk({vecs[i].name, "_busy_idle"}, busy, 0);
        end

        // Backpressure: result held while lane beats are ignored
        drive_run(vecs[0].beats, 4, 4'd14, 1'b0);
        wait_res("bp", lat);
        pop_cmp("bp");
        for (int c = 0; c < 5; c++) begin
            lane_vld = 1'b1; lane_in = 4'b1111;
            @(negedge clk);
            chk("bp_res_vld", res_vld, 1);
            chk("bp_countval", countval, 14);
        end
        lane_vld = 1'b0; res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        chk("bp_release_vld", res_vld, 0);
        chk("bp_release_busy", busy, 0);

        // Restart inside ACC: start + last beat forms a one-beat run
        @(negedge clk);
        start = 1'b1; lane_vld = 1'b1; lane_in = 4'b0011; last = 1'b0;
        @(negedge clk);
        start = 1'b0; lane_in = 4'b0011;
        @(negedge clk);
        start = 1'b1; lane_in = 4'b0001; last = 1'b1;
        begin
            exp_t e; e.cnt = 4'd1; e.ov = 1'b0; sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; lane_vld = 1'b0; last = 1'b0;
        wait_res("restart", lat);
        chk("restart_latency", lat, 2);
        pop_cmp("restart");

        // Handshake with start in HOLD: straight back to ACC with cleared result
        start = 1'b1; res_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0; res_rdy = 1'b0;
        chk("hs_start_busy", busy, 1);
        chk("hs_start_res_vld", res_vld, 0);
        chk("hs_start_countval", countval, 0);
        lane_vld = 1'b1; lane_in = 4'b0110; last = 1'b1;
        begin
            exp_t e; e.cnt = 4'd2; e.ov = 1'b0; sb.push_back(e);
        end
        @(negedge clk);
        lane_vld = 1'b0; last = 1'b0;
        wait_res("hs_start", lat);
        chk("hs_start_latency", lat, 2);
        pop_cmp("hs_start");
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;

        // Reset mid-run after overflow has already been flagged
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            start = (b == 0); lane_vld = 1'b1; lane_in = 4'b1111; last = 1'b0;
        end
        @(negedge clk);
        start = 1'b0; lane_vld = 1'b0;
        @(negedge clk);
        chk("mid_overflow_set", overflow, 1);
        chk("mid_busy_set", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_countval", countval, 0);
        chk("mid_rst_res_vld", res_vld, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        lane_vld = 1'b1; lane_in = 4'b1111; last = 1'b1;
        @(negedge clk);
        lane_vld = 1'b0; last = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("orphan_last_res_vld", res_vld, 0);
            chk("orphan_last_busy", busy, 0);
        end

        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
